multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Parametrised timing/state core for the multicycle CPU: generates the per-instruction stage count,
//  registers ALU flags and the decode mode bit at fixed stages, and detects program halt.
//  Sits beside PC/Control/reg_file/alu in top_level and replaces the inline stage counter and flag flops.
//  Adds stall, halt state, retired-instruction count and optional single-step.
// PARAMETERS
//  STAGES      4         stages per instruction (>=2); stage counts 0..STAGES-1
//  SW          $clog2(STAGES)  stage width (derived, do not override)
//  D           12        program counter width
//  HALT_ADDR   2**D-1    PC value that terminates the program
//  FLAG_STAGE  2         stage in which ALU flags are captured (< STAGES)
//  CW          16        retired-instruction counter width
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     synchronous, active-high
//  stall        in   1     hold current stage, no captures, no count
//  prog_ctr     in   D     current PC from PC block
//  alu_flags    in   5     {carry,lt,gt,equal,zero} from ALU, combinational
//  mode_we      in   1     decoder requests mode update this instruction
//  mode_next    in   1     new mode value
//  step_req     in   1     single-step pulse (only with STEP_DEBUG_EN; else absent)
//  stage        out  SW    current stage
//  last_stage   out  1     stage==STAGES-1 && state==RUN
//  flags_q      out  5     registered flags, same bit order as alu_flags
//  mode_q       out  1     registered mode
//  done         out  1     sticky halt indication
//  retired      out  CW    instructions completed since reset, wraps at 2**CW
// BEHAVIOUR
//  Reset: stage=0, flags_q=0, mode_q=0, done=0, retired=0, state=RUN. Reset dominates every other input.
//  States: RUN, HALTED (and PAUSED with STEP_DEBUG_EN).
//  adv = (state==RUN) && !stall.
//  RUN: on adv, stage <= (stage==STAGES-1) ? 0 : stage+1; !adv holds stage.
//  Flags: flags_q <= alu_flags on the cycle stage==FLAG_STAGE && adv; otherwise held. Stalled cycles never capture.
//  Mode: mode_q <= mode_next when stage==STAGES-1 && adv && mode_we, so the new mode is visible from stage 0
//   of the next instruction.
//  Retire: retired <= retired+1 when stage==STAGES-1 && adv; the counter wraps modulo 2**CW.
//  Halt: in RUN with stage==0 and prog_ctr==HALT_ADDR, the next state is HALTED and done <= 1.
//   This applies even if stall=1. Stage stays 0, and flags, mode and retired freeze.
//   HALTED exits only on reset.
//  done is registered: it rises 1 cycle after the halting stage-0 cycle.
//  last_stage is combinational from the stage and state registers.
//  Reset mid-instruction: next cycle stage=0. No partial capture completes.
// CONFIGURATION
//  STEP_DEBUG_EN defined:
//   - RUN->PAUSED when stage==STAGES-1 && adv, after retire and mode update.
//   - PAUSED holds stage=0 until step_req=1. The next state is RUN and one full instruction executes.
//   - Halt check has priority over PAUSED: PC==HALT_ADDR at stage 0 -> HALTED.
//   - step_req while RUN or HALTED is ignored.
//  STEP_DEBUG_EN undefined: no step_req port, no PAUSED state, free-running.
// STRUCTURE
//  isa_pkg: flag_t packed struct {carry,lt,gt,equal,zero}; seq_state_e enum {RUN,HALTED,PAUSED};
//   flag bit-index localparams.
//  One sub-module: stage_counter (SW-bit wrap counter with enable, wrap pulse output).
//  Flag, mode, halt FSM and retire logic stay in multicycle_sequencer.
// TESTING
//  1 Reset, no stall, STAGES=4: stage 0,1,2,3,0,... each cycle; retired=1 after 4 cycles, 2 after 8.
//  2 alu_flags=5'b00001 only during stage 2 -> flags_q=5'b00001 from stage 3. Change alu_flags during stage 3
//    -> no update.
//  3 stall=1 for 3 cycles at stage 2 with alu_flags=5'b10000 -> stage stays 2, flags_q unchanged;
//    release -> captured 5'b10000.
//  4 mode_we=1, mode_next=1 in stage 1 only -> mode_q stays 0.
//    mode_we=1 held through stage 3 -> mode_q=1 at next stage 0.
//  5 prog_ctr=12'hFFF at stage 0 -> done=1 next cycle, stage frozen 0, retired frozen.
//    Assert reset -> done=0, stage=0.
//  6 STEP_DEBUG_EN: after 1st instruction stage holds 0 for 10 cycles.
//    step_req pulse -> exactly 4 stages then hold; retired increments by 1.

Source files
------------

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isa_pkg
// Description : Shared types for the multicycle CPU sequencer.
//               It holds the ALU flag layout, the sequencer state encoding and
//               the bit indices of each flag within the 5-bit flag bus.
// Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

  // The flag bus is ordered {carry,lt,gt,equal,zero}, with zero at bit 0.
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_EQUAL = 1;
  localparam int FLAG_GT    = 2;
  localparam int FLAG_LT    = 3;
  localparam int FLAG_CARRY = 4;

  typedef struct packed {
    logic carry;
    logic lt;
    logic gt;
    logic equal;
    logic zero;
  } flag_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    PAUSED = 2'd2
  } seq_state_e;

endpackage : isa_pkg
`default_nettype wire

// File: rtl/multicycle_sequencer_stage_counter.sv
`default_nettype none
// ============================================================================
// Module      : stage_counter
// Description : A counter of width W that counts 0..N-1 and then wraps to 0.
//               It advances only while en is high. The wrap output is
//               combinational: it is high on the enabled cycle that wraps the
//               count from N-1 back to 0.
// Ports       : clk, reset (sync, active-high), en -> count[W-1:0], wrap
// Revision    : 1.0 - initial release
// ============================================================================
module stage_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_top;

  assign at_top = (count_q == W'(N - 1));
  assign wrap   = en && at_top;
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = at_top ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : stage_counter
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Timing and state core for the multicycle CPU.
//               It generates the per-instruction stage count, captures the
//               ALU flags in FLAG_STAGE, and updates the mode bit at the end
//               of each instruction. It counts retired instructions and
//               detects the halt PC.
//               Optional macro STEP_DEBUG_EN adds a PAUSED state and a
//               step_req input that together give single-step execution.
// Ports       : clk, reset (sync, active-high), stall, prog_ctr[D-1:0],
//               alu_flags[4:0], mode_we, mode_next, [step_req]
//               -> stage[SW-1:0], last_stage, flags_q[4:0], mode_q, done,
//                  retired[CW-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
  import isa_pkg::*;
#(
  parameter int          STAGES     = 4,
  parameter int          SW         = $clog2(STAGES),
  parameter int          D          = 12,
  parameter logic [D-1:0] HALT_ADDR = {D{1'b1}},
  parameter int          FLAG_STAGE = 2,
  parameter int          CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [D-1:0]  prog_ctr,
  input  logic [4:0]    alu_flags,
  input  logic          mode_we,
  input  logic          mode_next,
`ifdef STEP_DEBUG_EN
  input  logic          step_req,
`endif
  output logic [SW-1:0] stage,
  output logic          last_stage,
  output logic [4:0]    flags_q,
  output logic          mode_q,
  output logic          done,
  output logic [CW-1:0] retired
);

  seq_state_e    state_q, state_d;
  flag_t         flags_d;
  logic          mode_d;
  logic          done_q, done_d;
  logic [CW-1:0] retired_q, retired_d;

  logic          halt_hit;
  logic          adv;
  logic          instr_end;   // the last stage is advancing, so the instruction completes

  // Halt is sampled at stage 0, so a stall cannot hide it. The stage counter
  // is blocked on that cycle, which keeps the stage at 0 and stops any capture.
  assign halt_hit = (state_q != HALTED) && (stage == '0) && (prog_ctr == HALT_ADDR);
  assign adv      = (state_q == RUN) && !stall && !halt_hit;

  stage_counter #(
    .N (STAGES),
    .W (SW)
  ) u_stage_counter (
    .clk   (clk),
    .reset (reset),
    .en    (adv),
    .count (stage),
    .wrap  (instr_end)
  );

  assign last_stage = (stage == SW'(STAGES - 1)) && (state_q == RUN);
  assign done       = done_q;
  assign retired    = retired_q;

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    mode_d    = mode_q;
    retired_d = retired_q;
    flags_d   = flag_t'(flags_q);

    if (adv && (stage == SW'(FLAG_STAGE))) begin
      flags_d.carry = alu_flags[FLAG_CARRY];
      flags_d.lt    = alu_flags[FLAG_LT];
      flags_d.gt    = alu_flags[FLAG_GT];
      flags_d.equal = alu_flags[FLAG_EQUAL];
      flags_d.zero  = alu_flags[FLAG_ZERO];
    end

    if (instr_end) begin
      retired_d = retired_q + CW'(1);
      if (mode_we) begin
        mode_d = mode_next;
      end
    end

    case (state_q)
      RUN: begin
        if (halt_hit) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end
`ifdef STEP_DEBUG_EN
        else if (instr_end) begin
          state_d = PAUSED;
        end
`endif
      end
`ifdef STEP_DEBUG_EN
      PAUSED: begin
        if (halt_hit) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else if (step_req) begin
          state_d = RUN;
        end
      end
`endif
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      flags_q   <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      retired_q <= retired_d;
    end
  end

endmodule : multicycle_sequencer
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed self-checking bench for multicycle_sequencer
//               (STAGES=4, D=12, HALT_ADDR=12'hFFF, FLAG_STAGE=2, CW=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [11:0] prog_ctr;
  logic [4:0]  alu_flags;
  logic        mode_we;
  logic        mode_next;
`ifdef STEP_DEBUG_EN
  logic        step_req;
`endif
  logic [1:0]  stage;
  logic        last_stage;
  logic [4:0]  flags_q;
  logic        mode_q;
  logic        done;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_sequencer u_dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .prog_ctr   (prog_ctr),
    .alu_flags  (alu_flags),
    .mode_we    (mode_we),
    .mode_next  (mode_next),
`ifdef STEP_DEBUG_EN
    .step_req   (step_req),
`endif
    .stage      (stage),
    .last_stage (last_stage),
    .flags_q    (flags_q),
    .mode_q     (mode_q),
    .done       (done),
    .retired    (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, and the outputs are read at that point as well.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; prog_ctr = 12'h000; alu_flags = 5'b0;
    mode_we = 1'b0; mode_next = 1'b0;
`ifdef STEP_DEBUG_EN
    step_req = 1'b0;
`endif
    tick(); tick();
    check("rst_stage",   32'(stage), 0);
    check("rst_flags",   32'(flags_q), 0);
    check("rst_mode",    32'(mode_q), 0);
    check("rst_done",    32'(done), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_last",    32'(last_stage), 0);
    reset = 1'b0;

`ifndef STEP_DEBUG_EN
    // Test 1: the stage sequence is 0,1,2,3,0,... and the counter retires once every 4 cycles
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("seq_stage_%0d", i), 32'(stage), 32'(i % 4));
      check($sformatf("seq_last_%0d", i), 32'(last_stage), 32'((i % 4) == 3));
      if (i == 4) check("retired_4", 32'(retired), 1);
      if (i == 8) check("retired_8", 32'(retired), 2);
    end

    // Test 2: flags are captured only when leaving stage 2
    tick(); tick();                               // stage 2
    check("t2_at_stage2", 32'(stage), 2);
    alu_flags = 5'b00001;
    tick();                                       // stage 3
    check("t2_captured", 32'(flags_q), 32'h01);
    alu_flags = 5'b11110;
    tick();                                       // stage 0
    check("t2_no_update", 32'(flags_q), 32'h01);
    check("t2_retired", 32'(retired), 3);
    alu_flags = 5'b00000;

    // Test 3: a stall at stage 2 holds the stage and blocks the capture
    tick(); tick();                               // stage 2
    alu_flags = 5'b10000;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_stall_stage_%0d", i), 32'(stage), 2);
      check($sformatf("t3_stall_flags_%0d", i), 32'(flags_q), 32'h01);
    end
    check("t3_stall_retired", 32'(retired), 3);
    stall = 1'b0;
    tick();                                       // stage 3
    check("t3_release_stage", 32'(stage), 3);
    check("t3_release_flags", 32'(flags_q), 32'h10);
    alu_flags = 5'b00000;
    tick();                                       // stage 0
    check("t3_retired", 32'(retired), 4);

    // Test 4: the mode bit updates only at the end of the instruction
    tick();                                       // stage 1
    mode_we = 1'b1; mode_next = 1'b1;
    tick();                                       // stage 2
    mode_we = 1'b0;
    check("t4_mid_mode", 32'(mode_q), 0);
    tick(); tick();                               // stage 0
    check("t4_no_mode", 32'(mode_q), 0);
    check("t4_flags_cleared", 32'(flags_q), 0);
    mode_we = 1'b1;
    tick(); tick(); tick();                       // stage 3
    check("t4_stage3_mode", 32'(mode_q), 0);
    tick();                                       // stage 0
    check("t4_mode_set", 32'(mode_q), 1);
    check("t4_stage0", 32'(stage), 0);
    check("t4_retired", 32'(retired), 6);
    mode_we = 1'b0; mode_next = 1'b0;

    // Test 5: halt detection, freezing and recovery
    prog_ctr = 12'hFFF;
    check("t5_pre_done", 32'(done), 0);
    tick();
    check("t5_done", 32'(done), 1);
    check("t5_stage", 32'(stage), 0);
    alu_flags = 5'b11111; mode_we = 1'b1; mode_next = 1'b0; prog_ctr = 12'h000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_frozen_stage_%0d", i), 32'(stage), 0);
    end
    check("t5_frozen_retired", 32'(retired), 6);
    check("t5_frozen_flags", 32'(flags_q), 0);
    check("t5_frozen_mode", 32'(mode_q), 1);
    check("t5_sticky_done", 32'(done), 1);
    check("t5_last", 32'(last_stage), 0);
    alu_flags = 5'b0; mode_we = 1'b0;
    reset = 1'b1;
    tick();
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_stage", 32'(stage), 0);
    check("t5_rst_retired", 32'(retired), 0);
    check("t5_rst_mode", 32'(mode_q), 0);
    // A halt must still be detected while stall is held high.
    reset = 1'b0; stall = 1'b1; prog_ctr = 12'hFFF;
    tick();
    check("t5_stall_halt", 32'(done), 1);
    // Reset in the middle of an instruction returns the stage to 0.
    reset = 1'b1; tick(); reset = 1'b0; stall = 1'b0; prog_ctr = 12'h000;
    tick(); tick();
    check("t5_mid_stage", 32'(stage), 2);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t5_mid_rst_stage", 32'(stage), 0);
    check("t5_mid_rst_done", 32'(done), 0);
`else
    // Test 6: single-step mode
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t6_first_%0d", i), 32'(stage), 32'(i % 4));
    end
    check("t6_retired1", 32'(retired), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t6_hold_%0d", i), 32'(stage), 0);
    end
    check("t6_hold_retired", 32'(retired), 1);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("t6_step_stage0", 32'(stage), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t6_step_%0d", i), 32'(stage), 32'(i % 4));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_rehold_%0d", i), 32'(stage), 0);
    end
    check("t6_retired2", 32'(retired), 2);
    // While PAUSED, a halt takes priority over a step request.
    prog_ctr = 12'hFFF; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("t6_pause_halt", 32'(done), 1);
    tick();
    check("t6_halt_stage", 32'(stage), 0);
    check("t6_halt_retired", 32'(retired), 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_multicycle_sequencer
`default_nettype wire
